// File: rtl/axis_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_stream_fifo
//  Description : Synchronous AXI4-Stream FIFO with a registered
//                first-word-fall-through head. Carries every sideband field
//                bit-exact and reports fill level and complete-packet count.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_stream_fifo #(
    parameter int DATA_WIDTH  = 1024,
    parameter int TSTRB_WIDTH = DATA_WIDTH / 8,
    parameter int TKEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 16,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 256,
    parameter int DEPTH       = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,

    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [TSTRB_WIDTH-1:0]       s_axis_tstrb,
    input  logic [TKEEP_WIDTH-1:0]       s_axis_tkeep,
    input  logic                         s_axis_tlast,
    input  logic [ID_WIDTH-1:0]          s_axis_tid,
    input  logic [DEST_WIDTH-1:0]        s_axis_tdest,
    input  logic [USER_WIDTH-1:0]        s_axis_tuser,

    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [TSTRB_WIDTH-1:0]       m_axis_tstrb,
    output logic [TKEEP_WIDTH-1:0]       m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic [ID_WIDTH-1:0]          m_axis_tid,
    output logic [DEST_WIDTH-1:0]        m_axis_tdest,
    output logic [USER_WIDTH-1:0]        m_axis_tuser,

    output logic [$clog2(DEPTH):0]       level,
    output logic [$clog2(DEPTH):0]       pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = DATA_WIDTH + TSTRB_WIDTH + TKEEP_WIDTH + 1
                      + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    // Storage holds every beat, including the one mirrored in the head register.
    logic [BW-1:0] mem [DEPTH];

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr_nxt;
    logic [AW:0]   rd_ptr_nxt;
    logic [AW:0]   level_q;
    logic [AW:0]   pkt_q;
    logic [AW:0]   avail_nxt;
    logic          not_full;
    logic          full_nxt;
    logic          push;
    logic          pop;
    logic          load_head;
    logic [BW-1:0] in_beat;
    logic [BW-1:0] head_word;

    assign push      = s_axis_tvalid & s_axis_tready;
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign in_beat   = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
                        s_axis_tid, s_axis_tdest, s_axis_tuser};

    // Ready is held low while reset is asserted and is high as soon as it is released.
    assign s_axis_tready = aresetn & not_full;
    assign level         = level_q;
    assign pkt_count     = pkt_q;

    // Next pointers, next-full flag and head-refill decision.
    always_comb begin
        wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
        rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
        full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                     (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
        // Beats already in memory that remain after this cycle's pop; a beat
        // written on this same edge is not yet readable and is picked up next cycle.
        avail_nxt  = level_q - {{AW{1'b0}}, pop};
        load_head  = (avail_nxt != '0) && (pop || !m_axis_tvalid);
        head_word  = mem[rd_ptr_nxt[AW-1:0]];
    end

    // Beat storage write port; contents need no reset since pointers gate every read.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_beat;
        end
    end

    // Pointers, fill level, packet count and registered not-full flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            pkt_q    <= '0;
            not_full <= 1'b1;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            not_full <= !full_nxt;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            case ({push & s_axis_tlast, pop & m_axis_tlast})
                2'b10:   pkt_q <= pkt_q + 1'b1;
                2'b01:   pkt_q <= pkt_q - 1'b1;
                default: pkt_q <= pkt_q;
            endcase
        end
    end

    // Registered head: refilled after a pop or when idle, held stable while stalled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
            m_axis_tdest  <= '0;
            m_axis_tuser  <= '0;
        end else if (load_head) begin
            m_axis_tvalid <= 1'b1;
            {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
             m_axis_tid, m_axis_tdest, m_axis_tuser} <= head_word;
        end else if (pop) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_stream_fifo
//  Description : Directed self-checking bench for axis_stream_fifo with a
//                queue scoreboard for head payload ordering and stability.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_stream_fifo;

    localparam int DW    = 1024;
    localparam int SW    = DW / 8;
    localparam int KW    = DW / 8;
    localparam int IW    = 16;
    localparam int DEW   = 8;
    localparam int UW    = 256;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int BW    = DW + SW + KW + 1 + IW + DEW + UW;

    typedef logic [1023:0] cval_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [SW-1:0] s_axis_tstrb = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic [IW-1:0] s_axis_tid = '0;
    logic [DEW-1:0] s_axis_tdest = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [IW-1:0] m_axis_tid;
    logic [DEW-1:0] m_axis_tdest;
    logic [UW-1:0] m_axis_tuser;
    logic [LW-1:0] level;
    logic [LW-1:0] pkt_count;

    axis_stream_fifo #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .DEST_WIDTH (DEW),
        .USER_WIDTH (UW),
        .DEPTH      (DEPTH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser),
        .level         (level),
        .pkt_count     (pkt_count)
    );

    always #5 aclk = ~aclk;

    int            checks = 0;
    int            errors = 0;
    logic [BW-1:0] exp_q[$];
    bit            stalled = 1'b0;
    bit            last_push_ok = 1'b0;
    bit            last_pop = 1'b0;

    task automatic check(input string tag, input cval_t obs, input cval_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] simple_beat(input logic [31:0] d, input bit last);
        return {DW'(d), {SW{1'b1}}, {KW{1'b1}}, last, IW'(d), DEW'(d), UW'(~d)};
    endfunction

    function automatic logic [BW-1:0] rand_beat(input bit last);
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        for (int i = 0; i < SW / 32; i++) s[i*32 +: 32] = $urandom();
        for (int i = 0; i < KW / 32; i++) k[i*32 +: 32] = $urandom();
        for (int i = 0; i < UW / 32; i++) u[i*32 +: 32] = $urandom();
        return {d, s, k, last, IW'($urandom()), DEW'($urandom()), u};
    endfunction

    // Head must always match the scoreboard front and never drop while stalled.
    task automatic monitor();
        logic [BW-1:0] h;
        logic [BW-1:0] e;
        if (aresetn) begin
            if (stalled) check("valid_hold", cval_t'(m_axis_tvalid), cval_t'(1));
            if (m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", cval_t'(m_axis_tvalid), cval_t'(0));
                end else begin
                    h = {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
                         m_axis_tid, m_axis_tdest, m_axis_tuser};
                    e = exp_q[0];
                    check("head_hi",   cval_t'(h[BW-1 -: 512]),   cval_t'(e[BW-1 -: 512]));
                    check("head_lo",   cval_t'(h[BW-513 -: 512]), cval_t'(e[BW-513 -: 512]));
                    check("head_side", cval_t'(h[BW-DW-1:0]),     cval_t'(e[BW-DW-1:0]));
                end
            end
        end
    endtask

    task automatic next();
        @(negedge aclk);
        monitor();
    endtask

    // Apply inputs for the coming edge and record which handshakes it will complete.
    task automatic drive(input bit push, input logic [BW-1:0] b, input bit pop);
        s_axis_tvalid = push;
        {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
         s_axis_tid, s_axis_tdest, s_axis_tuser} = b;
        m_axis_tready = pop;
        last_pop      = m_axis_tvalid && pop;
        last_push_ok  = push && s_axis_tready;
        if (last_pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (last_push_ok) exp_q.push_back(b);
        stalled = m_axis_tvalid && !pop;
    endtask

    task automatic run_stream(input int n, input bit rand_ready, input int budget,
                              output int pops, output int first_pop, output int last_pop_c);
        logic [BW-1:0] b;
        bit have;
        int sent;
        bit rdy;
        have = 1'b0; sent = 0; pops = 0; first_pop = -1; last_pop_c = -1; b = '0;
        for (int c = 0; c < budget; c++) begin
            next();
            if (sent < n && !have) begin
                b = rand_beat(1'($urandom_range(0, 1)));
                have = 1'b1;
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(have, b, rdy);
            if (last_push_ok) begin sent++; have = 1'b0; end
            if (last_pop) begin
                pops++;
                if (first_pop < 0) first_pop = c;
                last_pop_c = c;
            end
            if (sent == n && !have && exp_q.size() == 0) break;
        end
        check("stream_sent",  cval_t'(sent), cval_t'(n));
        check("stream_drain", cval_t'(exp_q.size()), cval_t'(0));
        next();
        drive(1'b0, '0, 1'b0);
    endtask

    int pops;
    int fp;
    int lp;

    initial begin
        // Reset state
        #1;
        check("rst_tvalid", cval_t'(m_axis_tvalid), cval_t'(0));
        check("rst_tready", cval_t'(s_axis_tready), cval_t'(0));
        check("rst_level",  cval_t'(level),         cval_t'(0));
        check("rst_pkt",    cval_t'(pkt_count),     cval_t'(0));
        check("rst_tdata",  cval_t'(m_axis_tdata[511:0]), cval_t'(0));
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        next();
        check("rel_tready", cval_t'(s_axis_tready), cval_t'(1));

        // Single beat: one-cycle write-to-output latency
        drive(1'b1, simple_beat(32'hA5, 1'b1), 1'b1);
        next();
        check("t1_valid_lat", cval_t'(m_axis_tvalid), cval_t'(0));
        check("t1_level1",    cval_t'(level),         cval_t'(1));
        check("t1_pkt1",      cval_t'(pkt_count),     cval_t'(1));
        drive(1'b0, '0, 1'b1);
        next();
        check("t1_valid",     cval_t'(m_axis_tvalid), cval_t'(1));
        check("t1_tdata",     cval_t'(m_axis_tdata[31:0]), cval_t'(32'hA5));
        check("t1_tlast",     cval_t'(m_axis_tlast),  cval_t'(1));
        drive(1'b0, '0, 1'b1);
        next();
        check("t1_level0",    cval_t'(level),         cval_t'(0));
        check("t1_pkt0",      cval_t'(pkt_count),     cval_t'(0));
        check("t1_valid0",    cval_t'(m_axis_tvalid), cval_t'(0));

        // Fill to full, then pop with a simultaneous write attempt (no full bypass)
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, simple_beat(32'h100 + i, 1'b0), 1'b0);
            next();
        end
        check("t2_full_tready", cval_t'(s_axis_tready), cval_t'(0));
        check("t2_full_level",  cval_t'(level),         cval_t'(16));
        drive(1'b1, simple_beat(32'h999, 1'b1), 1'b1);
        next();
        check("t2_tready_back", cval_t'(s_axis_tready), cval_t'(1));
        check("t2_level15",     cval_t'(level),         cval_t'(15));
        check("t2_pkt0",        cval_t'(pkt_count),     cval_t'(0));
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, 1'b1);
            next();
        end
        check("t2_drained", cval_t'(level), cval_t'(0));
        check("t2_q_empty", cval_t'(exp_q.size()), cval_t'(0));
        drive(1'b0, '0, 1'b0);

        // Continuous stream: 100 pops on 100 consecutive cycles once primed
        run_stream(100, 1'b0, 300, pops, fp, lp);
        check("t3_pops",    cval_t'(pops),    cval_t'(100));
        check("t3_first",   cval_t'(fp),      cval_t'(2));
        check("t3_no_gaps", cval_t'(lp - fp), cval_t'(99));
        check("t3_level",   cval_t'(level),   cval_t'(0));

        // Random backpressure
        run_stream(60, 1'b1, 1000, pops, fp, lp);
        check("t4_pops",  cval_t'(pops),      cval_t'(60));
        check("t4_level", cval_t'(level),     cval_t'(0));
        check("t4_pkt",   cval_t'(pkt_count), cval_t'(0));

        // Three 4-beat packets, drain one packet, then one more beat
        next();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, simple_beat(32'h500 + i, (i % 4) == 3), 1'b0);
            next();
        end
        check("t5_level12", cval_t'(level),     cval_t'(12));
        check("t5_pkt3",    cval_t'(pkt_count), cval_t'(3));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            next();
        end
        check("t5_level8",  cval_t'(level),     cval_t'(8));
        check("t5_pkt2",    cval_t'(pkt_count), cval_t'(2));
        drive(1'b0, '0, 1'b1);
        next();
        drive(1'b0, '0, 1'b0);
        check("t6_level7",  cval_t'(level),     cval_t'(7));

        // Asynchronous reset mid-operation
        #2;
        aresetn = 1'b0;
        #1;
        exp_q.delete();
        stalled = 1'b0;
        check("t6_rst_valid",  cval_t'(m_axis_tvalid), cval_t'(0));
        check("t6_rst_level",  cval_t'(level),         cval_t'(0));
        check("t6_rst_pkt",    cval_t'(pkt_count),     cval_t'(0));
        check("t6_rst_tready", cval_t'(s_axis_tready), cval_t'(0));
        check("t6_rst_tdata",  cval_t'(m_axis_tdata[511:0]), cval_t'(0));
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        next();
        check("t6_rel_tready", cval_t'(s_axis_tready), cval_t'(1));
        check("t6_rel_valid",  cval_t'(m_axis_tvalid), cval_t'(0));
        drive(1'b1, simple_beat(32'h5EED, 1'b1), 1'b1);
        next();
        check("t6_lat_valid",  cval_t'(m_axis_tvalid), cval_t'(0));
        check("t6_level1",     cval_t'(level),         cval_t'(1));
        drive(1'b0, '0, 1'b1);
        next();
        check("t6_fresh_valid", cval_t'(m_axis_tvalid), cval_t'(1));
        check("t6_fresh_data",  cval_t'(m_axis_tdata[31:0]), cval_t'(32'h5EED));
        drive(1'b0, '0, 1'b1);
        next();
        check("t6_end_level", cval_t'(level),     cval_t'(0));
        check("t6_end_pkt",   cval_t'(pkt_count), cval_t'(0));
        drive(1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
